note_seq_ctrl: RTL and testbench
================================

# note_seq_ctrl

Parametrised note-sequencer controller for the music device. It arbitrates between note loading and playback, and keeps a write pointer for loading and a read pointer for playback over a note memory of 2^ADDR_W slots. It paces playback with an internal step divider and adds a programmable sequence length, loop mode, pause and abort. It sits between the debounced active-low pushbuttons and switches and the note RAM / tone generator datapath.

## Interface
- ADDR_W, 4: note memory address width; 2^ADDR_W slots.
- TICK_DIV, 25000000: clk cycles per playback step (0.5 s at 50 MHz); must be ≥2.
- DIV_W, 25: divider counter width; must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; forces the reset state immediately, released synchronously.
- load_n  input  1  active-low load request (held while a note is being entered).
- playback  input  1  active-low playback start request.
- stop_n  input  1  active-low abort of playback or pause.
- pause  input  1  level; high freezes playback.
- loop  input  1  level; high repeats the sequence indefinitely.
- last_idx  input  ADDR_W  index of the last note in the sequence (length − 1).
- ld_note  output  1  high in LOAD; write enable to note RAM.
- ld_play  output  1  high in PLAY.
- paused  output  1  high in PAUSE.
- busy  output  1  high in PLAY or PAUSE.
- wr_addr  output  ADDR_W  note RAM write address.
- note_counter  output  ADDR_W  note RAM read address during playback.
- step  output  1  combinational; high in the cycle before note_counter advances or wraps.
- done  output  1  registered one-cycle pulse at the end of non-looped playback.

## Operation
- States: IDLE, LOAD, PLAY, PAUSE. ld_note, ld_play, paused and busy are decoded from registered state only (Moore).
- IDLE:
  - load_n=0 → LOAD. load_n has priority over playback.
  - else playback=0 → PLAY. On this transition: divider cleared to 0, note_counter cleared to 0, last_idx captured into len_q.
  - else stay in IDLE.
- LOAD:
  - Stay while load_n=0.
  - On load_n=1 → IDLE. On the same edge, wr_addr increments; it wraps to 0 when wr_addr ≥ live last_idx.
- PLAY:
  - Divider counts 0..TICK_DIV−1, then returns to 0.
  - step = (state==PLAY) & (div==TICK_DIV−1) & stop_n.
  - On step with note_counter < len_q: note_counter increments.
  - On step with note_counter == len_q: note_counter ← 0. If loop=1, stay in PLAY. If loop=0, go to IDLE and assert done on the next cycle.
- PLAY with pause=1 (and no step in the same cycle) → PAUSE. A step in that cycle is taken first; pause is honoured on the next cycle.
- PAUSE:
  - Divider and note_counter frozen.
  - pause=0 → PLAY; counting resumes from the frozen divider value.
- stop_n=0 in PLAY or PAUSE → IDLE, note_counter ← 0, divider ← 0, no done. stop_n has priority over step, pause and loop.
- stop_n is ignored in IDLE and LOAD.
- len_q is fixed for the whole playback run; changes to last_idx during PLAY or PAUSE have no effect.
- wr_addr is not affected by playback or stop. Only reset clears it.

## Timing
- Reset values: state IDLE; ld_note=ld_play=paused=busy=0; wr_addr=0; note_counter=0; divider=0; len_q=0; done=0. step=0 because state is IDLE.
- Request to output latency is one cycle: load_n sampled low at edge N gives ld_note=1 after edge N. playback behaves the same for ld_play.
- Note 0 is presented for exactly TICK_DIV cycles after the PLAY entry edge. Every later note is also held for TICK_DIV cycles, excluding paused cycles.
- done is high exactly one cycle, coincident with the first IDLE cycle after the final step.
- Sequence length is last_idx+1. With last_idx=0 a single note plays.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously, regardless of state.

## Test plan
- Load: TICK_DIV=4, three load_n pulses of 2 cycles each with last_idx=15 → ld_note high 2 cycles per pulse; wr_addr reads 1, 2, 3 after each release.
- Wrap: last_idx=2, four load pulses → wr_addr sequence 1, 2, 0, 1.
- One-shot playback: TICK_DIV=4, last_idx=3, loop=0, one-cycle playback pulse → note_counter 0,1,2,3 each held 4 cycles; step high 4 times; done pulses once, 16 cycles after PLAY entry; ld_play=0 afterwards.
- Loop and pause: last_idx=1, loop=1 → note_counter 0,1,0,1,… with no done. pause=1 for 5 cycles mid-note → paused=1 and counter frozen; the note completes its remaining cycles after pause=0.
- Abort and priority: stop_n=0 in the same cycle as a step → IDLE, note_counter=0, no done. In IDLE with load_n=0 and playback=0 together → LOAD entered.
- Async reset: reset asserted mid-PLAY between clock edges → outputs go to their reset values immediately; after release, playback restarts only on a new playback request.

Source files
------------

// File: rtl/note_seq_ctrl.sv
// Note-sequencer controller: arbitrates note loading against paced playback and
// owns the note RAM write pointer and the playback read pointer.
module note_seq_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 25000000,
    parameter int DIV_W    = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_n,
    input  logic              playback,
    input  logic              stop_n,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last_idx,
    output logic              ld_note,
    output logic              ld_play,
    output logic              paused,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] note_counter,
    output logic              step,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        PAUSE
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ADDR_W-1:0] note_q, note_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              done_q, done_d;

    // stop_n masks step so an abort on the final tick never looks like a completed note
    assign step = (state_q == PLAY) && (div_q == DIV_LAST) && stop_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            note_q  <= '0;
            wr_q    <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            note_q  <= note_d;
            wr_q    <= wr_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        note_d  = note_q;
        wr_d    = wr_q;
        len_d   = len_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!load_n) begin
                    state_d = LOAD;
                end else if (!playback) begin
                    state_d = PLAY;
                    div_d   = '0;
                    note_d  = '0;
                    len_d   = last_idx;
                end
            end
            LOAD: begin
                // Wrap uses the live last_idx so loading follows the length being set up
                if (load_n) begin
                    state_d = IDLE;
                    wr_d    = (wr_q >= last_idx) ? '0 : wr_q + 1'b1;
                end
            end
            PLAY: begin
                if (!stop_n) begin
                    state_d = IDLE;
                    div_d   = '0;
                    note_d  = '0;
                end else if (step) begin
                    div_d = '0;
                    if (note_q < len_q) begin
                        note_d = note_q + 1'b1;
                    end else begin
                        note_d = '0;
                        if (!loop) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    // The cycle that samples pause still counts as a played cycle
                    div_d = div_q + 1'b1;
                    if (pause) begin
                        state_d = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (!stop_n) begin
                    state_d = IDLE;
                    div_d   = '0;
                    note_d  = '0;
                end else if (!pause) begin
                    state_d = PLAY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ld_note      = (state_q == LOAD);
    assign ld_play      = (state_q == PLAY);
    assign paused       = (state_q == PAUSE);
    assign busy         = (state_q == PLAY) || (state_q == PAUSE);
    assign wr_addr      = wr_q;
    assign note_counter = note_q;
    assign done         = done_q;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Self-checking bench for note_seq_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_note_seq_ctrl;

    localparam int AW = 4;
    localparam int T  = 4;
    localparam int DW = 3;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_PLAY  = 2;
    localparam int M_PAUSE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_n;
    logic          playback;
    logic          stop_n;
    logic          pause;
    logic          loop;
    logic [AW-1:0] last_idx;
    logic          ld_note;
    logic          ld_play;
    logic          paused;
    logic          busy;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] note_counter;
    logic          step;
    logic          done;

    int checks = 0;
    int errors = 0;

    note_seq_ctrl #(
        .ADDR_W   (AW),
        .TICK_DIV (T),
        .DIV_W    (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_n       (load_n),
        .playback     (playback),
        .stop_n       (stop_n),
        .pause        (pause),
        .loop         (loop),
        .last_idx     (last_idx),
        .ld_note      (ld_note),
        .ld_play      (ld_play),
        .paused       (paused),
        .busy         (busy),
        .wr_addr      (wr_addr),
        .note_counter (note_counter),
        .step         (step),
        .done         (done)
    );

    always #5 clk = ~clk;

    // pos counts played cycles since the start of the current pass through the sequence
    typedef struct {
        int mode;
        int wr;
        int len;
        int pos;
        int done;
    } model_t;

    model_t m;

    function automatic model_t modelReset();
        model_t r;
        r.mode = M_IDLE;
        r.wr   = 0;
        r.len  = 0;
        r.pos  = 0;
        r.done = 0;
        return r;
    endfunction

    function automatic model_t modelNext(model_t s, logic ldN, logic pbN, logic stN,
                                         logic ps, logic lp, int lastIdx);
        model_t n;
        n      = s;
        n.done = 0;
        case (s.mode)
            M_IDLE: begin
                if (!ldN) n.mode = M_LOAD;
                else if (!pbN) begin
                    n.mode = M_PLAY;
                    n.pos  = 0;
                    n.len  = lastIdx;
                end
            end
            M_LOAD: begin
                if (ldN) begin
                    n.mode = M_IDLE;
                    n.wr   = (s.wr >= lastIdx) ? 0 : s.wr + 1;
                end
            end
            M_PLAY: begin
                if (!stN) begin
                    n.mode = M_IDLE;
                    n.pos  = 0;
                end else begin
                    n.pos = s.pos + 1;
                    if (n.pos == (s.len + 1) * T) begin
                        n.pos = 0;
                        if (!lp) begin
                            n.mode = M_IDLE;
                            n.done = 1;
                        end
                    end else if (ps && (n.pos % T != 0)) begin
                        n.mode = M_PAUSE;
                    end
                end
            end
            default: begin
                if (!stN) begin
                    n.mode = M_IDLE;
                    n.pos  = 0;
                end else if (!ps) begin
                    n.mode = M_PLAY;
                end
            end
        endcase
        return n;
    endfunction

    // Output vector: {ld_note, ld_play, paused, busy, step, done, wr_addr, note_counter}
    function automatic logic [13:0] expVec(model_t s, logic stN);
        logic stepE;
        stepE = (s.mode == M_PLAY) && (s.pos % T == T - 1) && stN;
        return {s.mode == M_LOAD, s.mode == M_PLAY, s.mode == M_PAUSE,
                (s.mode == M_PLAY) || (s.mode == M_PAUSE), stepE, s.done != 0,
                AW'(s.wr), AW'(s.pos / T)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= modelReset();
        else        m <= modelNext(m, load_n, playback, stop_n, pause, loop, int'(last_idx));
    end

    always @(negedge clk) begin
        checks++;
        if ({ld_note, ld_play, paused, busy, step, done, wr_addr, note_counter} !== expVec(m, stop_n)) begin
            errors++;
            $display("[TB] FAIL cycle_outputs t=%0t actual=%b expected=%b", $time,
                     {ld_note, ld_play, paused, busy, step, done, wr_addr, note_counter},
                     expVec(m, stop_n));
        end
    end

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        int stepCnt;
        int doneCnt;
        int found;
        int wrapExp[4];

        wrapExp  = '{1, 2, 0, 1};
        reset    = 1'b0;
        load_n   = 1'b1;
        playback = 1'b1;
        stop_n   = 1'b1;
        pause    = 1'b0;
        loop     = 1'b0;
        last_idx = '0;
        applyStimulus(2);
        checkOutput("reset_ld_note", int'(ld_note), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_wr_addr", int'(wr_addr), 0);
        checkOutput("reset_note_counter", int'(note_counter), 0);
        checkOutput("reset_step", int'(step), 0);
        checkOutput("reset_done", int'(done), 0);
        reset = 1'b1;
        applyStimulus(1);

        // Three two-cycle load pulses with full-length sequence
        last_idx = 4'd15;
        for (int i = 1; i <= 3; i++) begin
            load_n = 1'b0;
            applyStimulus(1);
            checkOutput("load_ld_note_c1", int'(ld_note), 1);
            applyStimulus(1);
            checkOutput("load_ld_note_c2", int'(ld_note), 1);
            load_n = 1'b1;
            applyStimulus(1);
            checkOutput("load_wr_addr", int'(wr_addr), i);
            checkOutput("load_ld_note_off", int'(ld_note), 0);
        end

        // Write pointer wrap against a short sequence
        reset = 1'b0;
        #1;
        reset    = 1'b1;
        last_idx = 4'd2;
        for (int i = 0; i < 4; i++) begin
            load_n = 1'b0;
            applyStimulus(1);
            load_n = 1'b1;
            applyStimulus(1);
            checkOutput("wrap_wr_addr", int'(wr_addr), wrapExp[i]);
        end

        // One-shot playback of four notes
        last_idx = 4'd3;
        loop     = 1'b0;
        playback = 1'b0;
        applyStimulus(1);
        playback = 1'b1;
        checkOutput("oneshot_ld_play", int'(ld_play), 1);
        stepCnt = 0;
        doneCnt = 0;
        for (int k = 0; k < 16; k++) begin
            checkOutput("oneshot_note_counter", int'(note_counter), k / T);
            if (step) stepCnt++;
            if (done) doneCnt++;
            applyStimulus(1);
        end
        checkOutput("oneshot_step_count", stepCnt, 4);
        checkOutput("oneshot_early_done", doneCnt, 0);
        checkOutput("oneshot_done", int'(done), 1);
        checkOutput("oneshot_ld_play_off", int'(ld_play), 0);
        applyStimulus(1);
        checkOutput("oneshot_done_one_cycle", int'(done), 0);

        // Looped two-note playback with a five-cycle pause in note 1
        last_idx = 4'd1;
        loop     = 1'b1;
        playback = 1'b0;
        applyStimulus(1);
        playback = 1'b1;
        applyStimulus(5);
        checkOutput("loop_note_before_pause", int'(note_counter), 1);
        pause = 1'b1;
        applyStimulus(1);
        checkOutput("pause_paused", int'(paused), 1);
        applyStimulus(4);
        checkOutput("pause_frozen_note", int'(note_counter), 1);
        checkOutput("pause_still_paused", int'(paused), 1);
        pause = 1'b0;
        applyStimulus(1);
        checkOutput("resume_ld_play", int'(ld_play), 1);
        checkOutput("resume_note", int'(note_counter), 1);
        applyStimulus(1);
        checkOutput("resume_note_last", int'(note_counter), 1);
        applyStimulus(1);
        checkOutput("loop_wrap_note", int'(note_counter), 0);
        checkOutput("loop_no_done", int'(done), 0);

        // Abort coinciding with a step
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            if (step) found = 1;
            else applyStimulus(1);
        end
        checkOutput("abort_step_seen", found, 1);
        stop_n = 1'b0;
        applyStimulus(1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_note", int'(note_counter), 0);
        checkOutput("abort_done", int'(done), 0);
        stop_n = 1'b1;
        applyStimulus(1);
        checkOutput("abort_done_late", int'(done), 0);

        // load_n wins over playback in IDLE
        load_n   = 1'b0;
        playback = 1'b0;
        applyStimulus(1);
        checkOutput("prio_ld_note", int'(ld_note), 1);
        checkOutput("prio_ld_play", int'(ld_play), 0);
        load_n   = 1'b1;
        playback = 1'b1;
        applyStimulus(1);

        // Asynchronous reset between clock edges mid-playback
        playback = 1'b0;
        applyStimulus(1);
        playback = 1'b1;
        applyStimulus(3);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("areset_busy", int'(busy), 0);
        checkOutput("areset_ld_play", int'(ld_play), 0);
        checkOutput("areset_note", int'(note_counter), 0);
        checkOutput("areset_wr_addr", int'(wr_addr), 0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        applyStimulus(3);
        checkOutput("areset_no_restart", int'(busy), 0);
        playback = 1'b0;
        applyStimulus(1);
        playback = 1'b1;
        checkOutput("areset_new_request", int'(ld_play), 1);
        stop_n = 1'b0;
        applyStimulus(1);
        stop_n = 1'b1;

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            if (load_n) load_n = ($urandom_range(0, 24) != 0);
            else        load_n = ($urandom_range(0, 2) == 0);
            playback = ($urandom_range(0, 20) != 0);
            stop_n   = ($urandom_range(0, 60) != 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            if ($urandom_range(0, 50) == 0) loop = ~loop;
            if ($urandom_range(0, 9) == 0) last_idx = AW'($urandom_range(0, 15));
            applyStimulus(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
